ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives PS/2 keyboard frames (scan code set 2) on the raw `ps2_clk`/`ps2_data` lines, removes break (`F0`) and extended (`E0`) prefixes, and translates make/break codes into a 7-bit ASCII key code plus a release strobe. It sits directly upstream of the player movement stage: `keyCode` holds the ASCII code of the key currently held, and `released` marks key-up events.

## Interface
- `FILTER_LEN`, 8: consecutive identical `ps2_clk` samples required before the filtered clock changes state (range 2–255).
- `TIMEOUT_CYCLES`, 6500: `clk` cycles without a falling edge before a frame in progress is aborted (100 µs at 65 MHz).
- `clk` input 1: system clock, 65 MHz.
- `rst` input 1: reset, synchronous, active-high.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `keyCode` output 7: ASCII code of the last accepted make code; 0 when no key is held.
- `released` output 1: one-cycle strobe on an accepted break of a mapped key.
- `key_valid` output 1: one-cycle strobe on an accepted make of a mapped key.
- `frame_err` output 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning:** both lines pass through 2-FF synchronizers. `ps2_clk` then goes through a glitch filter: the filtered value changes only after `FILTER_LEN` equal consecutive samples. A falling edge on the filtered clock produces one sample pulse. `ps2_data` is sampled on that pulse.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample with data=0 (start bit), go to DATA. A sample with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first, with a 3-bit counter. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: the frame is good only if the stop bit is 1 and the odd-parity check over data+parity passes. A good frame raises the internal `byte_rdy` for one cycle. A bad frame pulses `frame_err` and discards the byte. Either way, return to IDLE.
- **Timeout:** in any state other than IDLE, a counter is cleared on each sample pulse. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE and `frame_err` pulses. The counter saturates; it does not wrap.
- **Byte decoder:**
  - `F0` sets the `brk` flag. `E0` sets the `ext` flag. Neither produces an output.
  - Any other byte is a code. After the code is processed, `brk` and `ext` are both cleared.
  - If `ext` is set, the code is ignored (no strobes, no `keyCode` change).
  - `frame_err` clears `brk` and `ext`.
- **Mapping (set 2 → ASCII, lowercase):**
  - Letters a–z per the standard set-2 table, e.g. `1C`→`61` 'a', `23`→`64` 'd', `1B`→`73` 's', `1D`→`77` 'w'.
  - Digits 0–9: `45`,`16`,`1E`,`26`,`25`,`2E`,`36`,`3D`,`3E`,`46` → `30`..`39`.
  - `29`→`20` (space), `5A`→`0D` (enter), `76`→`1B` (esc).
  - Unmapped codes produce nothing.
- **Make of a mapped code:** `keyCode` ← ASCII, and `key_valid` pulses.
- **Break of a mapped code:** `released` pulses. `keyCode` is cleared to 0 only if the broken key's ASCII equals the current `keyCode`; otherwise `keyCode` is unchanged.
- **Typematic repeat:** repeated makes of the same key re-load the same `keyCode` and pulse `key_valid` each time.
- **Reset values:** `keyCode`=0, `released`=0, `key_valid`=0, `frame_err`=0. FSM in IDLE, flags cleared, filter state=1, timeout counter=0.

## Timing
- Sample pulse: occurs 2 (synchronizer) + `FILTER_LEN` cycles after the raw falling edge, ±1 cycle.
- Byte latency: if the 11th sample pulse (stop bit) is in cycle N, `byte_rdy` is in N+1. `keyCode`, `key_valid`, `released` and `frame_err` update in N+2.
- Strobes are exactly one cycle wide. At most one strobe fires per byte.
- `rst` mid-frame: all state returns to reset values on the next edge. The partial frame is lost, and the next start bit is accepted normally.
- A sample pulse and a timeout in the same cycle: the sample wins, and the counter clears.

## Configuration
- `PS2_SHIFT_EN` defined:
  - Make/break of `12` (left shift) or `59` (right shift) sets/clears an independent held flag. Shift codes produce no strobes.
  - While either flag is set, letter makes map to uppercase (`1C`→`41` 'A', `23`→`44` 'D').
  - On a break, the uppercase/lowercase form is compared case-insensitively against `keyCode` when deciding whether to clear it.
- `PS2_SHIFT_EN` undefined: `12`/`59` are unmapped, and letters are always lowercase.

## Test plan
- Reset, then frame `23` → in N+2, `keyCode`=`64` and `key_valid` is high for 1 cycle. Then frames `F0`,`23` → `released` pulses and `keyCode`=0.
- Make `1C` then make `23`, then break `1C` → `released` pulses and `keyCode` stays `64`.
- Frame `23` with the parity bit inverted → `frame_err` pulses and `keyCode` is unchanged. Next, a valid `1C` → `keyCode`=`61`.
- Send 5 bits of a frame, then stall for `TIMEOUT_CYCLES`+2 → `frame_err` pulses once and the FSM is in IDLE. A following valid `23` decodes correctly.
- Frames `E0`,`1C` → no strobes and `keyCode` unchanged. 1-cycle glitches on `ps2_clk` shorter than `FILTER_LEN` → no bit shifted.
- With `PS2_SHIFT_EN`: `12`, `23` → `keyCode`=`44`. Then `F0`,`12`, `F0`,`23` → `keyCode`=0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 keyboard frame receiver and ASCII key decoder
//
// Purpose: conditions the raw PS/2 clock/data lines, receives 11-bit frames,
// strips F0 (break) / E0 (extended) prefixes and maps make/break codes to a
// 7-bit ASCII key code with one-cycle make, break and error strobes.
//
// Ports:
//   clk        system clock (65 MHz)
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock, asynchronous
//   ps2_data   raw PS/2 data, asynchronous
//   keyCode    ASCII of the key currently held, 0 when none
//   released   one-cycle strobe on a break of a mapped key
//   key_valid  one-cycle strobe on a make of a mapped key
//   frame_err  one-cycle strobe on parity, stop-bit or timeout error
//
// Optional feature macro: PS2_SHIFT_EN (left/right shift gives uppercase letters).

module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] keyCode,
  output logic       released,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Input conditioning
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample_q, sample_d;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never flip it.
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    sample_d = filt_q & ~filt_d;
  end

  // Frame receiver
  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    to_d    = to_q;
    if (state_q == IDLE || sample_q)   to_d = '0;
    else if (to_q != TW'(TIMEOUT_CYCLES)) to_d = to_q + 1'b1;

    case (state_q)
      IDLE: if (sample_q && !dat_s2_q) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (sample_q) begin
        sh_d  = {dat_s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (sample_q) begin
        par_d   = dat_s2_q;
        state_d = STOP;
      end
      STOP: if (sample_q) begin
        if (dat_s2_q && (^{sh_q, par_q})) rdy_d  = 1'b1;
        else                              ferr_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A sample in the same cycle takes priority over the timeout.
    if (state_q != IDLE && !sample_q && to_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  // Byte decoder
  function automatic logic [7:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = {1'b1, 7'h61}; 8'h32: map_code = {1'b1, 7'h62};
      8'h21: map_code = {1'b1, 7'h63}; 8'h23: map_code = {1'b1, 7'h64};
      8'h24: map_code = {1'b1, 7'h65}; 8'h2B: map_code = {1'b1, 7'h66};
      8'h34: map_code = {1'b1, 7'h67}; 8'h33: map_code = {1'b1, 7'h68};
      8'h43: map_code = {1'b1, 7'h69}; 8'h3B: map_code = {1'b1, 7'h6A};
      8'h42: map_code = {1'b1, 7'h6B}; 8'h4B: map_code = {1'b1, 7'h6C};
      8'h3A: map_code = {1'b1, 7'h6D}; 8'h31: map_code = {1'b1, 7'h6E};
      8'h44: map_code = {1'b1, 7'h6F}; 8'h4D: map_code = {1'b1, 7'h70};
      8'h15: map_code = {1'b1, 7'h71}; 8'h2D: map_code = {1'b1, 7'h72};
      8'h1B: map_code = {1'b1, 7'h73}; 8'h2C: map_code = {1'b1, 7'h74};
      8'h3C: map_code = {1'b1, 7'h75}; 8'h2A: map_code = {1'b1, 7'h76};
      8'h1D: map_code = {1'b1, 7'h77}; 8'h22: map_code = {1'b1, 7'h78};
      8'h35: map_code = {1'b1, 7'h79}; 8'h1A: map_code = {1'b1, 7'h7A};
      8'h45: map_code = {1'b1, 7'h30}; 8'h16: map_code = {1'b1, 7'h31};
      8'h1E: map_code = {1'b1, 7'h32}; 8'h26: map_code = {1'b1, 7'h33};
      8'h25: map_code = {1'b1, 7'h34}; 8'h2E: map_code = {1'b1, 7'h35};
      8'h36: map_code = {1'b1, 7'h36}; 8'h3D: map_code = {1'b1, 7'h37};
      8'h3E: map_code = {1'b1, 7'h38}; 8'h46: map_code = {1'b1, 7'h39};
      8'h29: map_code = {1'b1, 7'h20}; 8'h5A: map_code = {1'b1, 7'h0D};
      8'h76: map_code = {1'b1, 7'h1B};
      default: map_code = 8'h00;
    endcase
  endfunction

  function automatic logic [6:0] to_lower(input logic [6:0] a);
    to_lower = (a >= 7'h41 && a <= 7'h5A) ? a + 7'h20 : a;
  endfunction

  logic       brk_q, brk_d, ext_q, ext_d;
  logic [6:0] key_q, key_d;
  logic       rel_q, rel_d, kv_q, kv_d, err_q, err_d;
  logic       lsh_q, lsh_d, rsh_q, rsh_d;
  logic [7:0] map;
  logic [6:0] asc;
  logic       is_shift;

  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    key_d    = key_q;
    rel_d    = 1'b0;
    kv_d     = 1'b0;
    err_d    = ferr_q;
    lsh_d    = lsh_q;
    rsh_d    = rsh_q;
    map      = map_code(sh_q);
    asc      = map[6:0];
    is_shift = 1'b0;
`ifdef PS2_SHIFT_EN
    is_shift = (sh_q == 8'h12) || (sh_q == 8'h59);
    if ((lsh_q || rsh_q) && asc >= 7'h61 && asc <= 7'h7A) asc = asc - 7'h20;
`endif
    if (ferr_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rdy_q) begin
      if (sh_q == 8'hF0)      brk_d = 1'b1;
      else if (sh_q == 8'hE0) ext_d = 1'b1;
      else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          if (is_shift) begin
            if (sh_q == 8'h12) lsh_d = !brk_q;
            else               rsh_d = !brk_q;
          end else if (map[7]) begin
            if (brk_q) begin
              rel_d = 1'b1;
              if (to_lower(asc) == to_lower(key_q)) key_d = 7'h00;
            end else begin
              key_d = asc;
              kv_d  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1; clk_s2_q <= 1'b1; dat_s1_q <= 1'b1; dat_s2_q <= 1'b1;
      filt_q   <= 1'b1; filt_cnt_q <= '0; sample_q <= 1'b0;
      state_q  <= IDLE; bit_q <= 3'd0; sh_q <= 8'h00; par_q <= 1'b0;
      to_q     <= '0; rdy_q <= 1'b0; ferr_q <= 1'b0;
      brk_q    <= 1'b0; ext_q <= 1'b0; key_q <= 7'h00;
      rel_q    <= 1'b0; kv_q <= 1'b0; err_q <= 1'b0;
      lsh_q    <= 1'b0; rsh_q <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;  clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data; dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d; filt_cnt_q <= filt_cnt_d; sample_q <= sample_d;
      state_q  <= state_d; bit_q <= bit_d; sh_q <= sh_d; par_q <= par_d;
      to_q     <= to_d; rdy_q <= rdy_d; ferr_q <= ferr_d;
      brk_q    <= brk_d; ext_q <= ext_d; key_q <= key_d;
      rel_q    <= rel_d; kv_q <= kv_d; err_q <= err_d;
      lsh_q    <= lsh_d; rsh_q <= rsh_d;
    end
  end

  assign keyCode   = key_q;
  assign released  = rel_q;
  assign key_valid = kv_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder

module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 6500;
  localparam int HALF           = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] keyCode;
  logic       released, key_valid, frame_err;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyCode(keyCode), .released(released), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int kv_cnt = 0, rel_cnt = 0, err_cnt = 0;
  int last_kv_cyc = 0;
  int stop_fall_cyc = 0;
  int kv0, rel0, err0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt      <= kv_cnt + 1;
      last_kv_cyc <= cyc;
    end
    if (released)  rel_cnt <= rel_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wait_cyc(1);
    kv0 = kv_cnt; rel0 = rel_cnt; err0 = err_cnt;
  endtask

  task automatic check_deltas(input string tag, input int dkv, input int drel, input int derr);
    check({tag, "_kv"},  kv_cnt - kv0,   dkv);
    check({tag, "_rel"}, rel_cnt - rel0, drel);
    check({tag, "_err"}, err_cnt - err0, derr);
  endtask

  // Sends the first n bits of an 11-bit frame; glitch inserts a short low
  // pulse on ps2_clk during every high phase.
  task automatic send_bits(input logic [10:0] fr, input int n, input logic glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        wait_cyc(HALF / 4);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN / 2);
        ps2_clk = 1'b1;
        wait_cyc(HALF - HALF / 4 - FILTER_LEN / 2);
      end else begin
        wait_cyc(HALF);
      end
      stop_fall_cyc = cyc;
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    mk_frame = {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11, 1'b0);
    wait_cyc(60);
  endtask

  initial begin
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(1);
    check("rst_keycode", keyCode, 0);
    check("rst_released", released, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_frame_err", frame_err, 0);

    // Make 23 -> 'd'
    snap();
    send_byte(8'h23);
    check("make_d_key", keyCode, 7'h64);
    check_deltas("make_d", 1, 0, 0);
    check("make_d_latency_ok", ((last_kv_cyc - stop_fall_cyc) >= 11) &&
                               ((last_kv_cyc - stop_fall_cyc) <= 13), 1);

    // Break 23 clears the held key
    snap();
    send_byte(8'hF0);
    send_byte(8'h23);
    check("brk_d_key", keyCode, 0);
    check_deltas("brk_d", 0, 1, 0);

    // Break of a key other than the held one leaves keyCode alone
    snap();
    send_byte(8'h1C);
    check("make_a_key", keyCode, 7'h61);
    send_byte(8'h23);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("brk_other_key", keyCode, 7'h64);
    check_deltas("brk_other", 2, 1, 0);

    // Typematic repeat
    snap();
    send_byte(8'h1B);
    send_byte(8'h1B);
    check("repeat_s_key", keyCode, 7'h73);
    check_deltas("repeat_s", 2, 0, 0);

    // Digit, space, enter, esc mappings
    send_byte(8'h45); check("map_0", keyCode, 7'h30);
    send_byte(8'h46); check("map_9", keyCode, 7'h39);
    send_byte(8'h29); check("map_space", keyCode, 7'h20);
    send_byte(8'h5A); check("map_enter", keyCode, 7'h0D);
    send_byte(8'h76); check("map_esc", keyCode, 7'h1B);
    send_byte(8'h1D); check("map_w", keyCode, 7'h77);
    send_byte(8'h23); check("map_d", keyCode, 7'h64);

    // Parity error
    snap();
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11, 1'b0);
    wait_cyc(60);
    check("bad_par_key", keyCode, 7'h64);
    check_deltas("bad_par", 0, 0, 1);
    snap();
    send_byte(8'h1C);
    check("after_par_key", keyCode, 7'h61);
    check_deltas("after_par", 1, 0, 0);

    // Stop-bit error
    snap();
    send_bits(mk_frame(8'h23, 1'b0, 1'b1), 11, 1'b0);
    wait_cyc(60);
    check("bad_stop_key", keyCode, 7'h61);
    check_deltas("bad_stop", 0, 0, 1);

    // Timeout after 5 bits: exactly one error, then normal decode
    snap();
    send_bits(mk_frame(8'h23, 1'b0, 1'b0), 5, 1'b0);
    wait_cyc(TIMEOUT_CYCLES + 2);
    wait_cyc(HALF);
    check_deltas("timeout", 0, 0, 1);
    snap();
    send_byte(8'h23);
    check("after_to_key", keyCode, 7'h64);
    check_deltas("after_to", 1, 0, 0);

    // Break prefix cleared by a frame error: F0, bad frame, 23 is a make
    snap();
    send_byte(8'hF0);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11, 1'b0);
    wait_cyc(60);
    send_byte(8'h1C);
    check("err_clr_brk_key", keyCode, 7'h61);
    check_deltas("err_clr_brk", 1, 0, 1);

    // Extended code ignored, unmapped code ignored
    snap();
    send_byte(8'hE0);
    send_byte(8'h23);
    send_byte(8'h05);
    check("ext_key", keyCode, 7'h61);
    check_deltas("ext_unmapped", 0, 0, 0);

    // Glitches shorter than FILTER_LEN, with data low, then glitchy frame
    snap();
    ps2_data = 1'b0;
    for (int g = 1; g < FILTER_LEN; g += 3) begin
      ps2_clk = 1'b0;
      wait_cyc(g);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(20);
    send_bits(mk_frame(8'h23, 1'b0, 1'b0), 11, 1'b1);
    wait_cyc(60);
    check("glitch_key", keyCode, 7'h64);
    check_deltas("glitch", 1, 0, 0);

    // Reset mid-frame
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5, 1'b0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    check("midrst_key", keyCode, 0);
    snap();
    send_byte(8'h1C);
    check("after_rst_key", keyCode, 7'h61);
    check_deltas("after_rst", 1, 0, 0);

`ifdef PS2_SHIFT_EN
    snap();
    send_byte(8'h12);
    send_byte(8'h23);
    check("shift_D_key", keyCode, 7'h44);
    send_byte(8'hF0);
    send_byte(8'h12);
    check("shift_rel_key", keyCode, 7'h44);
    send_byte(8'hF0);
    send_byte(8'h23);
    check("shift_brk_key", keyCode, 0);
    check_deltas("shift", 1, 1, 0);
    snap();
    send_byte(8'h59);
    send_byte(8'h1C);
    check("rshift_A_key", keyCode, 7'h41);
    send_byte(8'hF0);
    send_byte(8'h59);
    send_byte(8'h1C);
    check("unshift_a_key", keyCode, 7'h61);
    check_deltas("rshift", 2, 0, 0);
`else
    snap();
    send_byte(8'h12);
    send_byte(8'h23);
    check("noshift_key", keyCode, 7'h64);
    check_deltas("noshift", 1, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
